// File: rtl/sat_pkg.sv
// Shared constants for the clause scanner: default sizing, literal/clause/row widths,
// literal field offsets and the scan FSM state encoding.
package sat_pkg;

  localparam int DEF_NUM_CLAUSES           = 64;
  localparam int DEF_VAR_ID_BITS           = 8;
  localparam int DEF_NUM_CLAUSES_PER_CYCLE = 16;
  localparam int DEF_NUM_VARS_PER_CLAUSE   = 3;

  localparam int DEF_LIT_W    = DEF_VAR_ID_BITS + 1;
  localparam int DEF_CLAUSE_W = DEF_LIT_W * DEF_NUM_VARS_PER_CLAUSE;
  localparam int DEF_ROW_W    = DEF_CLAUSE_W * DEF_NUM_CLAUSES_PER_CYCLE;

  // Within a literal the variable id sits at the bottom and the negate flag just above it.
  localparam int LIT_VAR_OFS = 0;

  function automatic int lit_neg_ofs(input int var_id_bits);
    return var_id_bits;
  endfunction

  function automatic int lit_base(input int clause, input int lit,
                                  input int var_id_bits, input int vars_per_clause);
    return clause * (var_id_bits + 1) * vars_per_clause + lit * (var_id_bits + 1);
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/clause_row_eval.sv
// Combinational evaluation of one storage row: flags every clause in the row whose
// literals are all false under the latched assignment.
module clause_row_eval
  import sat_pkg::*;
#(
  parameter int VAR_ID_BITS           = DEF_VAR_ID_BITS,
  parameter int NUM_CLAUSES_PER_CYCLE = DEF_NUM_CLAUSES_PER_CYCLE,
  parameter int NUM_VARS_PER_CLAUSE   = DEF_NUM_VARS_PER_CLAUSE
) (
  input  logic [(VAR_ID_BITS+1)*NUM_VARS_PER_CLAUSE*NUM_CLAUSES_PER_CYCLE-1:0] i_slice,
  input  logic [2**VAR_ID_BITS-1:0]                                            i_assignment,
  output logic [NUM_CLAUSES_PER_CYCLE-1:0]                                     o_unsat_mask
);

  logic [VAR_ID_BITS-1:0] w_var;
  logic                   w_neg;
  logic                   w_clause_sat;

  always_comb begin
    o_unsat_mask = '0;
    w_var        = '0;
    w_neg        = 1'b0;
    w_clause_sat = 1'b0;
    for (int c = 0; c < NUM_CLAUSES_PER_CYCLE; c++) begin
      w_clause_sat = 1'b0;
      for (int j = 0; j < NUM_VARS_PER_CLAUSE; j++) begin
        w_var = i_slice[lit_base(c, j, VAR_ID_BITS, NUM_VARS_PER_CLAUSE) + LIT_VAR_OFS +: VAR_ID_BITS];
        w_neg = i_slice[lit_base(c, j, VAR_ID_BITS, NUM_VARS_PER_CLAUSE) + lit_neg_ofs(VAR_ID_BITS)];
        w_clause_sat = w_clause_sat | (i_assignment[w_var] ^ w_neg);
      end
      o_unsat_mask[c] = ~w_clause_sat;
    end
  end

endmodule

// File: rtl/clause_scanner.sv
// Walks clause storage one row per cycle, checking every clause against a latched assignment;
// reports satisfiability, the lowest failing clause and the unsatisfied-clause count.
module clause_scanner
  import sat_pkg::*;
#(
  parameter int NUM_CLAUSES           = DEF_NUM_CLAUSES,
  parameter int VAR_ID_BITS           = DEF_VAR_ID_BITS,
  parameter int NUM_CLAUSES_PER_CYCLE = DEF_NUM_CLAUSES_PER_CYCLE,
  parameter int NUM_VARS_PER_CLAUSE   = DEF_NUM_VARS_PER_CLAUSE,
  parameter int PTR_BITS              = $clog2(NUM_CLAUSES / NUM_CLAUSES_PER_CYCLE)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic                                 full_scan,
  input  logic [2**VAR_ID_BITS-1:0]            assignment,
  output logic [PTR_BITS-1:0]                  row_ptr,
  input  logic [(VAR_ID_BITS+1)*NUM_VARS_PER_CLAUSE*NUM_CLAUSES_PER_CYCLE-1:0] memory_slice,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 sat,
  output logic [$clog2(NUM_CLAUSES)-1:0]       fail_clause,
  output logic [$clog2(NUM_CLAUSES+1)-1:0]     unsat_count
);

  localparam int NUM_ROWS = NUM_CLAUSES / NUM_CLAUSES_PER_CYCLE;
  localparam int FC_W     = $clog2(NUM_CLAUSES);
  localparam int CNT_W    = $clog2(NUM_CLAUSES + 1);

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [PTR_BITS-1:0]        r_row_ptr;
  logic [2**VAR_ID_BITS-1:0]  r_assign;
  logic                       r_full_scan;
  logic [CNT_W-1:0]           r_count;
  logic                       r_fail_found;
  logic [FC_W-1:0]            r_fail_idx;
  logic                       r_busy;
  logic                       r_done;
  logic                       r_sat;
  logic [FC_W-1:0]            r_fail_clause;
  logic [CNT_W-1:0]           r_unsat_count;

  logic [NUM_CLAUSES_PER_CYCLE-1:0] w_unsat_mask;
  logic [CNT_W-1:0]           w_row_pop;
  logic [CNT_W-1:0]           w_count_nxt;
  logic [FC_W-1:0]            w_low_lane;
  logic [FC_W-1:0]            w_row_fail_idx;
  logic                       w_row_fail;
  logic                       w_last_row;
  logic                       w_start_ok;
  logic                       w_scan_end;

  clause_row_eval #(
    .VAR_ID_BITS          (VAR_ID_BITS),
    .NUM_CLAUSES_PER_CYCLE(NUM_CLAUSES_PER_CYCLE),
    .NUM_VARS_PER_CLAUSE  (NUM_VARS_PER_CLAUSE)
  ) u_row_eval (
    .i_slice     (memory_slice),
    .i_assignment(r_assign),
    .o_unsat_mask(w_unsat_mask)
  );

  always_comb begin
    w_row_pop  = '0;
    w_low_lane = '0;
    for (int l = NUM_CLAUSES_PER_CYCLE - 1; l >= 0; l--) begin
      w_row_pop = w_row_pop + CNT_W'(w_unsat_mask[l]);
      if (w_unsat_mask[l]) w_low_lane = FC_W'(l);
    end
  end

  assign w_row_fail     = |w_unsat_mask;
  assign w_row_fail_idx = FC_W'(r_row_ptr) * FC_W'(NUM_CLAUSES_PER_CYCLE) + w_low_lane;
  assign w_count_nxt    = r_count + w_row_pop;
  assign w_last_row     = (r_row_ptr == PTR_BITS'(NUM_ROWS - 1));
  assign w_start_ok     = (r_state == ST_IDLE) && start;
  assign w_scan_end     = (r_state == ST_SCAN) && (w_last_row || (!r_full_scan && w_row_fail));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_SCAN;
      ST_SCAN: if (w_scan_end) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row_ptr     <= '0;
      r_assign      <= '0;
      r_full_scan   <= 1'b0;
      r_count       <= '0;
      r_fail_found  <= 1'b0;
      r_fail_idx    <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_sat         <= 1'b0;
      r_fail_clause <= '0;
      r_unsat_count <= '0;
    end else begin
      r_busy <= (w_state_nxt == ST_SCAN);
      r_done <= w_scan_end;
      if (w_start_ok) begin
        r_row_ptr    <= '0;
        r_count      <= '0;
        r_assign     <= assignment;
        r_full_scan  <= full_scan;
        r_fail_found <= 1'b0;
        r_fail_idx   <= '0;
      end
      if (r_state == ST_SCAN) begin
        r_count <= w_count_nxt;
        if (!w_last_row) r_row_ptr <= r_row_ptr + 1'b1;
        // Only the first failing row names the reported clause.
        if (w_row_fail && !r_fail_found) begin
          r_fail_found <= 1'b1;
          r_fail_idx   <= w_row_fail_idx;
        end
        if (w_scan_end) begin
          r_sat         <= (w_count_nxt == '0);
          r_unsat_count <= w_count_nxt;
          r_fail_clause <= r_fail_found ? r_fail_idx : (w_row_fail ? w_row_fail_idx : '0);
        end
      end
    end
  end

  assign row_ptr     = r_row_ptr;
  assign busy        = r_busy;
  assign done        = r_done;
  assign sat         = r_sat;
  assign fail_clause = r_fail_clause;
  assign unsat_count = r_unsat_count;

endmodule

// File: tb/tb_clause_scanner.sv
// Directed bench for clause_scanner: a clause-level model predicts timing and results,
// a per-cycle compare process checks the DUT, and literal expectations pin the model.
module tb_clause_scanner;
  import sat_pkg::*;

  localparam int NROWS = DEF_NUM_CLAUSES / DEF_NUM_CLAUSES_PER_CYCLE;
  localparam int NCPC  = DEF_NUM_CLAUSES_PER_CYCLE;
  localparam int NCL   = DEF_NUM_CLAUSES;
  localparam int CW    = DEF_CLAUSE_W;
  localparam int LW    = DEF_LIT_W;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  start = 1'b0;
  logic                  full_scan = 1'b0;
  logic [255:0]          assignment = '0;
  logic [1:0]            row_ptr;
  logic [DEF_ROW_W-1:0]  memory_slice;
  logic                  busy, done, sat;
  logic [5:0]            fail_clause;
  logic [6:0]            unsat_count;

  logic [DEF_ROW_W-1:0]  mem [NROWS];
  assign memory_slice = mem[row_ptr];

  always #5 clk = ~clk;

  clause_scanner dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .full_scan   (full_scan),
    .assignment  (assignment),
    .row_ptr     (row_ptr),
    .memory_slice(memory_slice),
    .busy        (busy),
    .done        (done),
    .sat         (sat),
    .fail_clause (fail_clause),
    .unsat_count (unsat_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [CW-1:0] make_clause(input logic [7:0] v0, input logic n0,
                                                input logic [7:0] v1, input logic n1,
                                                input logic [7:0] v2, input logic n2);
    return {n2, v2, n1, v1, n0, v0};
  endfunction

  function automatic bit clause_true(input logic [CW-1:0] cl, input logic [255:0] a);
    logic [7:0] v;
    for (int j = 0; j < 3; j++) begin
      v = cl[j*LW +: 8];
      if (a[v] ^ cl[j*LW + 8]) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic fill_all(input logic [CW-1:0] cl);
    for (int r = 0; r < NROWS; r++)
      for (int l = 0; l < NCPC; l++)
        mem[r][l*CW +: CW] = cl;
  endtask

  // Expected results derived clause by clause from the storage contents.
  int exp_cyc, exp_cnt, exp_fail;
  bit exp_sat;
  bit armed = 1'b0;
  int cyc = 0;
  int done_cyc = -1;

  task automatic model(input logic [255:0] a, input bit fs);
    bit unsat [NCL];
    int first_row;
    first_row = -1;
    exp_cnt   = 0;
    exp_fail  = 0;
    for (int g = 0; g < NCL; g++)
      unsat[g] = !clause_true(mem[g / NCPC][(g % NCPC)*CW +: CW], a);
    for (int g = NCL - 1; g >= 0; g--)
      if (unsat[g]) begin
        exp_fail  = g;
        first_row = g / NCPC;
      end
    for (int g = 0; g < NCL; g++)
      if (unsat[g] && (fs || first_row < 0 || g / NCPC <= first_row)) exp_cnt++;
    exp_cyc = (fs || first_row < 0) ? NROWS + 1 : first_row + 2;
    exp_sat = (exp_cnt == 0);
  endtask

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (armed) begin
      check("done_timing", 32'(done), 32'(cyc == exp_cyc));
      check("busy", 32'(busy), 32'(cyc >= 1 && cyc < exp_cyc));
      if (done) done_cyc = cyc;
      if (cyc >= exp_cyc) begin
        check("sat", 32'(sat), 32'(exp_sat));
        check("unsat_count", 32'(unsat_count), 32'(exp_cnt));
        if (!exp_sat) check("fail_clause", 32'(fail_clause), 32'(exp_fail));
      end
    end
  end

  // Issues start at cycle 0; with again=1 it keeps pulsing start with different inputs
  // through the scan and the done cycle, which must all be ignored.
  task automatic run_scan(input logic [255:0] a, input bit fs, input bit again);
    model(a, fs);
    done_cyc = -1;
    @(posedge clk); #1;
    assignment = a;
    full_scan  = fs;
    start      = 1'b1;
    cyc        = 0;
    armed      = 1'b1;
    for (int k = 1; k <= exp_cyc + 1; k++) begin
      @(posedge clk); #1;
      start = again && (k <= exp_cyc);
      if (again) begin
        assignment = ~a;
        full_scan  = ~fs;
      end
    end
    @(posedge clk);
    armed = 1'b0;
    start = 1'b0;
    assignment = a;
    full_scan  = fs;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [255:0] a;
    for (int r = 0; r < NROWS; r++) mem[r] = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_row_ptr", 32'(row_ptr), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_sat", 32'(sat), 0);
    check("rst_fail_clause", 32'(fail_clause), 0);
    check("rst_unsat_count", 32'(unsat_count), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // All clauses (x0|x1|x2), x1 true, early-exit mode: full walk, all satisfied.
    fill_all(make_clause(8'd0, 1'b0, 8'd1, 1'b0, 8'd2, 1'b0));
    a = '0; a[1] = 1'b1;
    run_scan(a, 1'b0, 1'b0);
    check("t1_done_cycle", 32'(done_cyc), 5);
    check("t1_sat", 32'(sat), 1);
    check("t1_unsat_count", 32'(unsat_count), 0);

    // Same clauses, all false: stop after row 0.
    run_scan('0, 1'b0, 1'b0);
    check("t2_done_cycle", 32'(done_cyc), 2);
    check("t2_sat", 32'(sat), 0);
    check("t2_fail_clause", 32'(fail_clause), 0);
    check("t2_unsat_count", 32'(unsat_count), 16);

    // Row 2 lanes 5 and 9 are (~x3|~x3|~x3), x0 and x3 true, full scan.
    fill_all(make_clause(8'd0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0));
    mem[2][5*CW +: CW] = make_clause(8'd3, 1'b1, 8'd3, 1'b1, 8'd3, 1'b1);
    mem[2][9*CW +: CW] = make_clause(8'd3, 1'b1, 8'd3, 1'b1, 8'd3, 1'b1);
    a = '0; a[0] = 1'b1; a[3] = 1'b1;
    run_scan(a, 1'b1, 1'b0);
    check("t3_done_cycle", 32'(done_cyc), 5);
    check("t3_fail_clause", 32'(fail_clause), 37);
    check("t3_unsat_count", 32'(unsat_count), 2);

    // Repeat with start re-pulsed in cycles 1-5 carrying different inputs.
    run_scan(a, 1'b1, 1'b1);
    check("t4_done_cycle", 32'(done_cyc), 5);
    check("t4_fail_clause", 32'(fail_clause), 37);
    check("t4_unsat_count", 32'(unsat_count), 2);

    // Edge variable ids: row 1 lane 15 = (x255|~x200|x7) is false; early exit on row 1.
    fill_all(make_clause(8'd0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0));
    mem[1][15*CW +: CW] = make_clause(8'd255, 1'b0, 8'd200, 1'b1, 8'd7, 1'b0);
    a = '0; a[0] = 1'b1; a[200] = 1'b1;
    run_scan(a, 1'b0, 1'b0);
    check("t5_done_cycle", 32'(done_cyc), 3);
    check("t5_fail_clause", 32'(fail_clause), 31);
    check("t5_unsat_count", 32'(unsat_count), 1);

    // Negated literal satisfies every clause under an all-zero assignment.
    fill_all(make_clause(8'd9, 1'b1, 8'd1, 1'b0, 8'd2, 1'b0));
    run_scan('0, 1'b1, 1'b0);
    check("t6_sat", 32'(sat), 1);
    check("t6_unsat_count", 32'(unsat_count), 0);

    // Every clause false with full scan: the count reaches its maximum.
    fill_all(make_clause(8'd0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0));
    run_scan('0, 1'b1, 1'b0);
    check("t7_done_cycle", 32'(done_cyc), 5);
    check("t7_unsat_count", 32'(unsat_count), 64);

    // Reset asserted in cycle 3 of a scan.
    @(posedge clk); #1;
    assignment = '0; full_scan = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("t8_busy_before_reset", 32'(busy), 1);
    check("t8_row_ptr_before_reset", 32'(row_ptr), 2);
    rst_n = 1'b0;
    #1;
    check("t8_rst_row_ptr", 32'(row_ptr), 0);
    check("t8_rst_busy", 32'(busy), 0);
    check("t8_rst_done", 32'(done), 0);
    check("t8_rst_sat", 32'(sat), 0);
    check("t8_rst_fail_clause", 32'(fail_clause), 0);
    check("t8_rst_unsat_count", 32'(unsat_count), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("t8_no_done_after_reset", 32'(done | busy), 0);
    end

    // Fresh scan after the aborted one.
    fill_all(make_clause(8'd0, 1'b0, 8'd1, 1'b0, 8'd2, 1'b0));
    a = '0; a[1] = 1'b1;
    run_scan(a, 1'b0, 1'b0);
    check("t9_done_cycle", 32'(done_cyc), 5);
    check("t9_sat", 32'(sat), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
